// File: rtl/rv_wb_pkg.sv
// Shared types for the RV32I writeback stage:
// writeback selects, load funct3 codes and the MEM/WB register layout.
package rv_wb_pkg;

  localparam int WB_XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSV  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic [WB_XLEN-1:0] pc;
    logic [4:0]         rd_addr;
    logic               rd_wren;
    wb_sel_e            wb_sel;
    logic [WB_XLEN-1:0] alu_data;
    logic [WB_XLEN-1:0] ld_data;
    logic [2:0]         ld_funct3;
    logic [1:0]         addr_lo;
  } mem_wb_t;

endpackage

// File: rtl/ld_align.sv
// Load data aligner: picks the byte/halfword lane of the
// memory word and sign- or zero-extends it to XLEN.
module ld_align
  import rv_wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    unique case (addr_lo)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
    endcase
  end

  // addr_lo[0] is ignored: misaligned halfwords trap upstream
  assign lane_h = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   value = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, lane_h};
      F3_LW:   value = word;
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, writeback mux,
// regfile write port and the retired-instruction counter.
module wb_stage
  import rv_wb_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic             i_mem_valid,
  input  logic [XLEN-1:0]  i_mem_pc,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_rd_wren,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic [XLEN-1:0]  i_mem_alu_data,
  input  logic [XLEN-1:0]  i_mem_ld_data,
  input  logic [2:0]       i_mem_ld_funct3,
  input  logic [1:0]       i_mem_addr_lo,
  output logic [4:0]       o_rd_addr,
  output logic [XLEN-1:0]  o_rd_data,
  output logic             o_rd_wren,
  output logic             o_wb_valid,
  output logic [XLEN-1:0]  o_wb_pc,
  output logic [CNT_W-1:0] o_retire_cnt
);

  mem_wb_t          q;
  mem_wb_t          cap;
  logic [CNT_W-1:0] retire_cnt;
  logic             commit;
  logic [XLEN-1:0]  ld_val;

  always_comb begin
    cap           = '0;
    cap.valid     = i_mem_valid;
    cap.done      = 1'b0;
    cap.pc        = i_mem_pc;
    cap.rd_addr   = i_mem_rd_addr;
    cap.rd_wren   = i_mem_rd_wren;
    cap.wb_sel    = wb_sel_e'(i_mem_wb_sel);
    cap.alu_data  = i_mem_alu_data;
    cap.ld_data   = i_mem_ld_data;
    cap.ld_funct3 = i_mem_ld_funct3;
    cap.addr_lo   = i_mem_addr_lo;
  end

  // done keeps a held instruction from committing twice
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q          <= '0;
      retire_cnt <= '0;
    end else begin
      if (commit)
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (i_flush) begin
        q.valid   <= 1'b0;
        q.rd_wren <= 1'b0;
        q.done    <= 1'b0;
      end else if (i_hold) begin
        q.done <= q.valid;
      end else begin
        q <= cap;
      end
    end
  end

  assign commit = q.valid & ~q.done;

  ld_align #(
    .XLEN(XLEN)
  ) u_ld_align (
    .funct3  (q.ld_funct3),
    .addr_lo (q.addr_lo),
    .word    (q.ld_data),
    .value   (ld_val)
  );

  always_comb begin
    o_rd_data = '0;
    unique case (q.wb_sel)
      WB_ALU:  o_rd_data = q.alu_data;
      WB_LOAD: o_rd_data = ld_val;
      WB_PC4:  o_rd_data = q.pc + XLEN'(4);
      WB_RSV:  o_rd_data = '0;
    endcase
  end

  assign o_rd_addr    = q.rd_addr;
  assign o_rd_wren    = commit & q.rd_wren & (q.rd_addr != 5'd0);
  assign o_wb_valid   = commit;
  assign o_wb_pc      = q.pc;
  assign o_retire_cnt = retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, hold, flush, mv, mwren;
  logic [31:0] mpc, malu, mld;
  logic [4:0]  mrd;
  logic [1:0]  msel, mlo;
  logic [2:0]  mf3;

  logic [4:0]  rd_addr, w_rd_addr;
  logic [31:0] rd_data, w_rd_data, wb_pc, w_wb_pc;
  logic        rd_wren, w_rd_wren, wb_valid, w_wb_valid;
  logic [63:0] cnt;
  logic [3:0]  w_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .i_clk(clk), .i_reset(rst), .i_hold(hold), .i_flush(flush),
    .i_mem_valid(mv), .i_mem_pc(mpc), .i_mem_rd_addr(mrd),
    .i_mem_rd_wren(mwren), .i_mem_wb_sel(msel),
    .i_mem_alu_data(malu), .i_mem_ld_data(mld),
    .i_mem_ld_funct3(mf3), .i_mem_addr_lo(mlo),
    .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_wren(rd_wren),
    .o_wb_valid(wb_valid), .o_wb_pc(wb_pc), .o_retire_cnt(cnt)
  );

  wb_stage #(.CNT_W(4)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_hold(hold), .i_flush(flush),
    .i_mem_valid(mv), .i_mem_pc(mpc), .i_mem_rd_addr(mrd),
    .i_mem_rd_wren(mwren), .i_mem_wb_sel(msel),
    .i_mem_alu_data(malu), .i_mem_ld_data(mld),
    .i_mem_ld_funct3(mf3), .i_mem_addr_lo(mlo),
    .o_rd_addr(w_rd_addr), .o_rd_data(w_rd_data), .o_rd_wren(w_rd_wren),
    .o_wb_valid(w_wb_valid), .o_wb_pc(w_wb_pc), .o_retire_cnt(w_cnt)
  );

  // Reference model: the instruction sitting in writeback, tagged
  // with an id; it retires the first cycle it is visible.
  logic        m_valid = 1'b0;
  int          m_id    = 0;
  int          last_id = -1;
  int          next_id = 1;
  logic [31:0] m_pc = '0, m_alu = '0, m_word = '0;
  logic [4:0]  m_rd = '0;
  logic        m_wren = 1'b0;
  logic [1:0]  m_sel = '0, m_lo = '0;
  logic [2:0]  m_f3 = '0;
  logic [63:0] m_cnt = '0;

  function automatic logic [31:0] ref_load(logic [2:0] f3,
                                           logic [1:0] lo,
                                           logic [31:0] w);
    int          sh = 8 * lo;
    logic [31:0] b  = (w >> sh) & 32'hFF;
    logic [31:0] h  = lo[1] ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic exp_valid();
    return m_valid && (m_id != last_id);
  endfunction

  function automatic logic exp_wren();
    return exp_valid() && m_wren && (m_rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_data();
    case (m_sel)
      2'd0:    return m_alu;
      2'd1:    return ref_load(m_f3, m_lo, m_word);
      2'd2:    return m_pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(logic v, logic [31:0] pc, logic [4:0] rd,
                       logic we, logic [1:0] sel, logic [31:0] alu,
                       logic [31:0] word, logic [2:0] f3,
                       logic [1:0] lo);
    mv = v; mpc = pc; mrd = rd; mwren = we; msel = sel;
    malu = alu; mld = word; mf3 = f3; mlo = lo;
  endtask

  task automatic bubble();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Advance one clock with the current inputs, update the model,
  // and leave time 1 unit past the edge for sampling.
  task automatic cycle();
    logic commit = exp_valid();
    @(posedge clk);
    if (rst) begin
      m_cnt = '0; m_valid = 1'b0; m_pc = '0; m_rd = '0;
      m_wren = 1'b0; m_sel = '0; m_alu = '0; m_word = '0;
      m_f3 = '0; m_lo = '0;
    end else begin
      if (commit) begin
        m_cnt   = m_cnt + 64'd1;
        last_id = m_id;
      end
      if (flush) begin
        m_valid = 1'b0;
      end else if (!hold) begin
        m_valid = mv; m_id = next_id; next_id++;
        m_pc = mpc; m_rd = mrd; m_wren = mwren; m_sel = msel;
        m_alu = malu; m_word = mld; m_f3 = mf3; m_lo = mlo;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    bubble();
    cycle(); cycle();
    rst = 1'b0;
    n_checks++;
    if ({wb_valid, rd_wren, rd_data, wb_pc, rd_addr, cnt} !== '0)
      $display("FAIL reset: valid=%b wren=%b data=%h pc=%h cnt=%0d want 0",
               wb_valid, rd_wren, rd_data, wb_pc, cnt);
    else n_pass++;
  endtask

  task automatic test_lw();
    drive(1'b1, 32'h100, 5'd5, 1'b1, 2'd1, 32'h0,
          32'hDEADBEEF, 3'd2, 2'd3);
    cycle();
    n_checks++;
    if ({rd_wren, rd_addr, rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL lw: wren=%b addr=%0d data=%h want 1 5 deadbeef",
               rd_wren, rd_addr, rd_data);
    else n_pass++;
    bubble();
    cycle();
    n_checks++;
    if (cnt !== 64'd1)
      $display("FAIL lw_cnt: cnt=%0d want 1", cnt);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0]  los [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] exps[7] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                             32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                             32'h000080FF};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h200, 5'd7, 1'b1, 2'd1, 32'h0,
            32'h80FF7F01, f3s[i], los[i]);
      cycle();
      n_checks++;
      if (rd_data !== exps[i])
        $display("FAIL load[%0d] f3=%0d lo=%0d: data=%h want %h",
                 i, f3s[i], los[i], rd_data, exps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_pc4_x0();
    drive(1'b1, 32'hFFFFFFFC, 5'd1, 1'b1, 2'd2, 32'h1234,
          32'h0, 3'd0, 2'd0);
    cycle();
    n_checks++;
    if ({rd_wren, rd_data} !== {1'b1, 32'h0})
      $display("FAIL pc4_wrap: wren=%b data=%h want 1 00000000",
               rd_wren, rd_data);
    else n_pass++;
    drive(1'b1, 32'h300, 5'd0, 1'b1, 2'd0, 32'h55, 32'h0, 3'd0, 2'd0);
    cycle();
    n_checks++;
    if ({rd_wren, wb_valid} !== 2'b01)
      $display("FAIL alu_x0: wren=%b valid=%b want 0 1",
               rd_wren, wb_valid);
    else n_pass++;
  endtask

  task automatic test_hold();
    int          n_wren = 0, n_valid = 0;
    logic [63:0] c0;
    bubble();
    cycle();
    c0 = m_cnt;
    drive(1'b1, 32'h400, 5'd9, 1'b1, 2'd0, 32'hA5A5, 32'h0, 3'd0, 2'd0);
    cycle();
    n_wren += int'(rd_wren); n_valid += int'(wb_valid);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_wren += int'(rd_wren); n_valid += int'(wb_valid);
    end
    hold = 1'b0;
    bubble();
    cycle();
    n_checks++;
    if (n_wren != 1 || n_valid != 1)
      $display("FAIL hold_once: wren_cycles=%0d valid_cycles=%0d want 1 1",
               n_wren, n_valid);
    else n_pass++;
    n_checks++;
    if (cnt !== c0 + 64'd1)
      $display("FAIL hold_cnt: cnt=%0d want %0d", cnt, c0 + 64'd1);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [63:0] c0;
    bubble();
    cycle();
    c0 = m_cnt;
    for (int k = 0; k < 2; k++) begin
      flush = 1'b1; hold = (k == 1);
      drive(1'b1, 32'h500, 5'd3, 1'b1, 2'd0, 32'h77, 32'h0, 3'd0, 2'd0);
      cycle();
      n_checks++;
      if ({wb_valid, rd_wren} !== 2'b00)
        $display("FAIL flush[%0d]: valid=%b wren=%b want 0 0",
                 k, wb_valid, rd_wren);
      else n_pass++;
      flush = 1'b0; hold = 1'b0;
      bubble();
      cycle();
      n_checks++;
      if (cnt !== c0)
        $display("FAIL flush_cnt[%0d]: cnt=%0d want %0d", k, cnt, c0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_commit();
    drive(1'b1, 32'h600, 5'd4, 1'b1, 2'd0, 32'h99, 32'h0, 3'd0, 2'd0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({cnt, wb_valid, rd_wren, rd_data, wb_pc} !== '0)
      $display("FAIL reset_commit: cnt=%0d valid=%b wren=%b data=%h want 0",
               cnt, wb_valid, rd_wren, rd_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 5'd2, 1'b1, 2'd0, 32'(i),
            32'h0, 3'd0, 2'd0);
      cycle();
    end
    bubble();
    cycle();
    n_checks++;
    if (w_cnt !== 4'd1 || cnt !== 64'd17)
      $display("FAIL wrap: narrow=%0d wide=%0d want 1 17", w_cnt, cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 12);
      hold  = ($urandom_range(0, 99) < 25);
      drive($urandom_range(0, 3) != 0, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom, $urandom,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      cycle();
      n_checks++;
      if ({wb_valid, rd_wren, rd_addr, wb_pc, rd_data, cnt} !==
          {exp_valid(), exp_wren(), m_rd, m_pc, exp_data(), m_cnt} ||
          {w_wb_valid, w_rd_wren, w_rd_addr, w_wb_pc, w_rd_data, w_cnt} !==
          {exp_valid(), exp_wren(), m_rd, m_pc, exp_data(), m_cnt[3:0]}) begin
        if (errs < 10)
          $display("FAIL random[%0d]: v=%b we=%b rd=%0d pc=%h d=%h c=%0d nc=%0d want v=%b we=%b rd=%0d pc=%h d=%h c=%0d",
                   i, wb_valid, rd_wren, rd_addr, wb_pc, rd_data, cnt, w_cnt,
                   exp_valid(), exp_wren(), m_rd, m_pc, exp_data(), m_cnt);
        errs++;
      end else n_pass++;
    end
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    bubble();
    test_reset();
    test_lw();
    test_loads();
    test_pc4_x0();
    test_hold();
    test_flush();
    test_reset_commit();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
